// File: rtl/ex_div_unit_pkg.sv
// Shared encodings for the EX-stage iterative divider: RV32M op codes and FSM states.
package ex_div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    DIV_S_IDLE = 2'b00,
    DIV_S_CALC = 2'b01,
    DIV_S_DONE = 2'b10
  } div_state_e;

  // Bit 0 of the op code marks the unsigned variants, bit 1 selects the remainder.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/ex_div_unit_div_step.sv
// One combinational restoring-division iteration: shift {rem,quo} left, trial-subtract the divisor.
module ex_div_unit_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  // rem < divisor always holds, so a non-negative trial fits in XLEN bits and
  // bit XLEN is a clean borrow flag.
  assign shifted = {rem, quo[XLEN-1]};
  assign trial   = shifted - {1'b0, divisor};

  assign rem_next = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
  assign quo_next = {quo[XLEN-2:0], ~trial[XLEN]};

endmodule

// File: rtl/ex_div_unit.sv
// Iterative radix-2 RV32M divider (DIV/DIVU/REM/REMU) for the EX stage.
// Optional macro DIV_EARLY_EXIT_EN: finish in one cycle when |a| < |b|.
module ex_div_unit
  import ex_div_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            ready,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] result
);

  div_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q;
  logic            sel_rem_q, neg_quo_q, neg_rem_q;

  logic            is_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_abs, b_abs;
  logic            fast_done;
  logic [XLEN-1:0] fast_result;
  logic [XLEN-1:0] rem_next, quo_next;
  logic [XLEN-1:0] quo_fix, rem_fix, calc_result;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    is_signed   = op_is_signed(op);
    a_neg       = is_signed & a[XLEN-1];
    b_neg       = is_signed & b[XLEN-1];
    a_abs       = a_neg ? -a : a;
    b_abs       = b_neg ? -b : b;
    fast_done   = 1'b0;
    fast_result = '0;
    // The special cases bypass the iteration; their results need no sign fix-up.
    if (b == '0) begin
      fast_done   = 1'b1;
      fast_result = op[1] ? a : '1;
    end else if (is_signed && a == {1'b1, {(XLEN-1){1'b0}}} && b == '1) begin
      fast_done   = 1'b1;
      fast_result = op[1] ? '0 : a;
    end
`ifdef DIV_EARLY_EXIT_EN
    else if (a_abs < b_abs) begin
      fast_done   = 1'b1;
      fast_result = op[1] ? a : '0;
    end
`endif
  end

  ex_div_unit_div_step #(.XLEN(XLEN)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvs_q),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  assign quo_fix     = neg_quo_q ? -quo_next : quo_next;
  assign rem_fix     = neg_rem_q ? -rem_next : rem_next;
  assign calc_result = sel_rem_q ? rem_fix : quo_fix;

  assign ready = (state == DIV_S_IDLE) || (state == DIV_S_DONE);
  assign busy  = (state == DIV_S_CALC);

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= DIV_S_IDLE;
      cnt       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      sel_rem_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result    <= '0;
      valid     <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (flush) begin
        state <= DIV_S_IDLE;
      end else begin
        case (state)
          DIV_S_IDLE, DIV_S_DONE: begin
            if (start) begin
              sel_rem_q <= op[1];
              neg_quo_q <= a_neg ^ b_neg;
              neg_rem_q <= a_neg;
              dvs_q     <= b_abs;
              if (fast_done) begin
                state  <= DIV_S_DONE;
                result <= fast_result;
                valid  <= 1'b1;
              end else begin
                state <= DIV_S_CALC;
                cnt   <= CNT_W'(XLEN);
                rem_q <= '0;
                quo_q <= a_abs;
              end
            end else begin
              state <= DIV_S_IDLE;
            end
          end
          DIV_S_CALC: begin
            rem_q <= rem_next;
            quo_q <= quo_next;
            cnt   <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
              state  <= DIV_S_DONE;
              result <= calc_result;
              valid  <= 1'b1;
            end
          end
          default: state <= DIV_S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_div_unit.sv
// Self-checking bench for ex_div_unit: directed vector table plus flush/back-to-back/reset sequences.
module tb_ex_div_unit;
  import ex_div_unit_pkg::*;

`ifdef DIV_EARLY_EXIT_EN
  localparam int SMALL_LAT = 1;
`else
  localparam int SMALL_LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        flush = 1'b0;
  logic        ready, busy, valid;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;

  ex_div_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .ready  (ready),
    .busy   (busy),
    .valid  (valid),
    .result (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Issues one op starting at the current cycle (cycle 0) and waits for valid.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] res, output int lat, output int busy_cyc);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom);
    lat = 1;
    busy_cyc = 0;
    while (!valid && lat < 100) begin
      if (busy) busy_cyc++;
      @(posedge clk); #1;
      lat++;
    end
    res = result;
  endtask

  initial begin
    logic [31:0] res;
    int lat, bc, seen;
    logic [31:0] held;

    vecs[0]  = '{DIV_OP_DIVU, 32'd100,      32'd7,        32'd14,        33};
    vecs[1]  = '{DIV_OP_REMU, 32'd100,      32'd7,        32'd2,         33};
    vecs[2]  = '{DIV_OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD,  33};
    vecs[3]  = '{DIV_OP_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF,  33};
    vecs[4]  = '{DIV_OP_DIV,  32'd5,        32'd0,        32'hFFFFFFFF,  1};
    vecs[5]  = '{DIV_OP_REMU, 32'd5,        32'd0,        32'd5,         1};
    vecs[6]  = '{DIV_OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000,  1};
    vecs[7]  = '{DIV_OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'd0,         1};
    vecs[8]  = '{DIV_OP_DIVU, 32'd3,        32'd10,       32'd0,         SMALL_LAT};
    vecs[9]  = '{DIV_OP_REMU, 32'd3,        32'd10,       32'd3,         SMALL_LAT};
    vecs[10] = '{DIV_OP_DIV,  32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD,  33};
    vecs[11] = '{DIV_OP_REM,  32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF,  33};
    vecs[12] = '{DIV_OP_DIVU, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF,  33};
    vecs[13] = '{DIV_OP_REM,  32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB,  1};
    vecs[14] = '{DIV_OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'd0,         SMALL_LAT};
    vecs[15] = '{DIV_OP_REMU, 32'hFFFFFFFF, 32'h10,       32'hF,         33};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",   {31'd0, busy},  32'd0);
    check("rst_valid",  {31'd0, valid}, 32'd0);
    check("rst_ready",  {31'd0, ready}, 32'd1);
    check("rst_result", result,         32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, bc);
      check($sformatf("v%0d_result", i), res, vecs[i].exp);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'(vecs[i].lat - 1));
      @(posedge clk); #1;
      check($sformatf("v%0d_valid_drop", i), {31'd0, valid}, 32'd0);
      check($sformatf("v%0d_result_held", i), result, vecs[i].exp);
    end
    held = vecs[15].exp;

    // Flush at cycle 10 of DIVU 100/7
    op = DIV_OP_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("flush_busy_before", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy_after",  {31'd0, busy},  32'd0);
    check("flush_ready_after", {31'd0, ready}, 32'd1);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (valid) seen = 1;
    end
    check("flush_no_valid",    32'(seen), 32'd0);
    check("flush_result_held", result,    held);

    // Back-to-back: DIVU 9/3, then DIVU 8/2 issued in the DONE cycle
    run_op(DIV_OP_DIVU, 32'd9, 32'd3, res, lat, bc);
    check("b2b_first_result",  res,         32'd3);
    check("b2b_first_latency", 32'(lat),    32'd33);
    check("b2b_ready_in_done", {31'd0, ready}, 32'd1);
    run_op(DIV_OP_DIVU, 32'd8, 32'd2, res, lat, bc);
    check("b2b_second_result",  res,      32'd4);
    check("b2b_second_latency", 32'(lat), 32'd33);
    @(posedge clk); #1;

    // flush and start in the same cycle: start is dropped
    op = DIV_OP_DIV; a = 32'd5; b = 32'd0; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush_start_valid", {31'd0, valid}, 32'd0);
    check("flush_start_busy",  {31'd0, busy},  32'd0);
    check("flush_start_result", result, 32'd4);

    // Asynchronous reset mid-CALC
    op = DIV_OP_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("midcalc_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("areset_busy",   {31'd0, busy},  32'd0);
    check("areset_valid",  {31'd0, valid}, 32'd0);
    check("areset_result", result,         32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (valid) seen = 1;
    end
    check("areset_no_valid", 32'(seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_div_unit.md
Name: ex_div_unit

Overview:
- Iterative radix-2 divider in the EX stage.
- Executes RV32M DIV/DIVU/REM/REMU over multiple cycles, replacing the single-cycle combinational divide path.
- Takes the same rs1/rs2 operands as the ALU; its result feeds the EX result mux alongside the ALU output.
- Raises busy so the hazard unit stalls IF/ID/EX until the result is valid.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  pipeline clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  issue request; sampled only when ready.
- op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- a  input  XLEN  dividend (rs1).
- b  input  XLEN  divisor (rs2).
- flush  input  1  abort in-flight op (branch mispredict / EX flush).
- ready  output  1  high in IDLE and DONE; start is accepted.
- busy  output  1  high in CALC; stall request.
- valid  output  1  one-cycle result strobe.
- result  output  XLEN  quotient or remainder; held until the next accepted start.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. While rst_n=0: state=IDLE, counter=0, busy=0, valid=0, result=0, internal regs=0.
- States: IDLE, CALC, DONE.
- IDLE: ready=1. On start=1:
  - Latch op, sign flags and absolute values |a|, |b|; signed ops only; unsigned ops use raw values.
  - b==0 -> DONE. Quotient=all ones; remainder=a (unmodified, signed or unsigned).
  - Signed op with a==2^(XLEN-1) and b==all ones -> DONE. Quotient=a; remainder=0.
  - Otherwise -> CALC with counter=XLEN, remainder reg=0, quotient reg=|a|.
- CALC: busy=1, ready=0. Each cycle performs one restoring step:
  - Shift {rem,quo} left 1.
  - trial = rem - |b|, computed XLEN+1 bits wide.
  - trial non-negative -> rem=trial and quo LSB=1; otherwise quo LSB=0.
  - Decrement counter; at counter==1 the step completes and state -> DONE.
- DONE: valid=1 for exactly one cycle; result registered on entry to DONE.
  - Quotient negated if signed op and sign(a)!=sign(b), excluding the special cases above.
  - Remainder negated if signed op and a negative.
  - REM/REMU select the remainder, DIV/DIVU the quotient.
  - Next state IDLE, or CALC/DONE if start=1 in this cycle (back-to-back issue, no bubble).
- Latency: start accepted at cycle 0.
  - Normal op: valid at cycle XLEN+1 (33 for XLEN=32).
  - Special cases: valid at cycle 1.
- start while busy=1 is ignored; no queueing.
- flush in any state -> IDLE next cycle, valid forced 0 that cycle, result unchanged.
  - flush with start in the same cycle: flush wins; start is dropped.
- Operands a/b/op may change after acceptance without effect.
- Asynchronous reset mid-CALC aborts immediately; no valid is produced.

Optional Feature:
- Macro: DIV_EARLY_EXIT_EN.
- Defined: in IDLE, if not a special case and |a| < |b| (unsigned compare of latched magnitudes), go directly to DONE with quotient=0 and remainder=a. valid at cycle 1.
- Undefined: such cases take the full XLEN+1 cycles. Results are bit-identical either way; only latency differs.

Decomposition:
- Shared package (defines.v): op encodings DIV_OP_DIV/DIVU/REM/REMU; state encodings DIV_S_IDLE/CALC/DONE. These sit next to the existing ALU_* codes.
- Sub-module div_step: combinational single restoring iteration; inputs rem, quo, divisor; outputs next rem, next quo. Keeps the FSM file focused on control and sign fix-up.

Test Plan:
- DIVU a=100, b=7 -> busy for 32 cycles, valid at cycle 33, result=14; REMU same operands -> result=2.
- DIV a=-7 (0xFFFFFFF9), b=2 -> result=0xFFFFFFFD (-3); REM same -> 0xFFFFFFFF (-1).
- DIV a=5, b=0 -> valid at cycle 1, result=0xFFFFFFFF; REMU a=5, b=0 -> result=5.
- DIV a=0x80000000, b=0xFFFFFFFF -> valid at cycle 1, result=0x80000000; REM -> result=0.
- Start DIVU 100/7, assert flush at cycle 10 -> busy=0 at cycle 11, valid never asserts. Then back-to-back start in a DONE cycle (DIVU 9/3, then DIVU 8/2) -> results 3 and 4, valids 33 cycles apart.
- rst_n pulled low mid-CALC -> busy, valid and result are 0 immediately (async); with DIV_EARLY_EXIT_EN, DIVU 3/10 -> valid at cycle 1, result=0, REMU -> 3.
